wires_module: RTL and testbench

Defusable "wires" puzzle: the module-side responder to the bomb controller's per-module `enable` / `module_defused` handshake. It debounces the physical wire switches and waits until all wires are intact before arming. On arming it latches a puzzle version. Cutting the correct wire raises `defused` (held); cutting any other wire emits a one-cycle `strike` pulse toward the strike/timer accumulator.

---
 rtl/wires_pkg.sv | 25 ++
 rtl/wires_module_debounce.sv | 45 ++++
 rtl/wires_module.sv | 106 ++++++++++
 tb/tb_wires_module.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wires_pkg.sv
// Shared types and constants for the wires puzzle module.
package wires_pkg;

    localparam int DEFAULT_NUM_WIRES = 6;

    // Encoding is visible on state_out and drives sprite selection.
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_INTACT = 2'd1,
        ARMED       = 2'd2,
        DEFUSED     = 2'd3
    } wires_state_t;

    // Wire that must be cut for each puzzle version, for the default wire count.
    localparam int TARGET_LUT [4] = '{1, 3, DEFAULT_NUM_WIRES - 1, 0};

    // Version 2 always targets the last wire, whatever the wire count.
    function automatic int target_wire(input logic [1:0] ver, input int num_wires);
        if (ver == 2'd2) begin
            return num_wires - 1;
        end
        return TARGET_LUT[ver];
    endfunction

endpackage

// File: rtl/wires_module_debounce.sv
// Single-bit synchronizer plus stability counter for one wire switch.
// Resets to 1 (intact) so leaving reset never looks like a cut.
module debounce #(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] count;

    // Two-flop synchronizer for the asynchronous switch input.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking so sync_b takes the old sync_a; a blocking chain collapses the two flops into one.
        if (!reset) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Follow the synchronized value only after it disagrees for DEBOUNCE_CYCLES samples in a row.
    always_ff @(posedge clock) begin
        if (!reset) begin
            level <= 1'b1;
            count <= '0;
        end else if (sync_b == level) begin
            count <= '0;
        end else if (count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level <= sync_b;
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/wires_module.sv
// Wires puzzle: debounces the wire switches, arms once all are intact,
// then reports the correct cut as defused and any other new cut as a strike.
module wires_module
    import wires_pkg::*;
#(
    parameter int NUM_WIRES       = DEFAULT_NUM_WIRES,
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           version,
    input  logic [NUM_WIRES-1:0] wires_in,
    output logic                 defused,
    output logic                 strike,
    output logic [1:0]           state_out,
    output logic [NUM_WIRES-1:0] cut_mask
);

    localparam int IDX_W = $clog2(NUM_WIRES);

    wires_state_t         state;
    logic [1:0]           ver_q;
    logic [NUM_WIRES-1:0] w;
    logic [NUM_WIRES-1:0] w_q;
    logic [NUM_WIRES-1:0] cut;
    logic [NUM_WIRES-1:0] new_cut;
    logic [IDX_W-1:0]     tgt;

    for (genvar i = 0; i < NUM_WIRES; i++) begin : g_wire
        debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock(clock),
            .reset(reset),
            .raw  (wires_in[i]),
            .level(w[i])
        );
    end

    // Registered 1->0 detection on the debounced wires; reconnections are ignored.
    always_ff @(posedge clock) begin
        if (!reset) begin
            w_q <= '1;
            cut <= '0;
        end else begin
            w_q <= w;
            cut <= w_q & ~w;
        end
    end

    // Target wire for the latched version and cuts not yet recorded since arming.
    always_comb begin
        tgt     = IDX_W'(target_wire(ver_q, NUM_WIRES));
        new_cut = cut & ~cut_mask;
    end

    // Puzzle FSM with registered defused/strike outputs; enable low overrides every state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            ver_q    <= '0;
            cut_mask <= '0;
            defused  <= 1'b0;
            strike   <= 1'b0;
        end else begin
            strike <= 1'b0;
            if (!enable) begin
                state   <= IDLE;
                defused <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= WAIT_INTACT;
                    end
                    WAIT_INTACT: begin
                        if (&w) begin
                            state    <= ARMED;
                            ver_q    <= version;
                            cut_mask <= '0;
                        end
                    end
                    ARMED: begin
                        cut_mask <= cut_mask | new_cut;
                        if (new_cut[tgt]) begin
                            state   <= DEFUSED;
                            defused <= 1'b1;
                        end else if (|new_cut) begin
                            strike <= 1'b1;
                        end
                    end
                    DEFUSED: begin
                        cut_mask <= cut_mask | cut;
                        defused  <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_wires_module.sv
// Scoreboard bench for wires_module with a short debounce window.
module tb_wires_module;

    localparam int N = 6;
    localparam int D = 4;

    // Target wire per version, taken straight from the puzzle rules for six wires.
    localparam int TGT [4] = '{1, 3, N - 1, 0};

    localparam int EV_STRIKE  = 1;
    localparam int EV_DEFUSED = 2;

    logic         clock    = 1'b0;
    logic         reset    = 1'b0;
    logic         enable   = 1'b0;
    logic [1:0]   version  = 2'd0;
    logic [N-1:0] wires_in = '1;
    logic         defused;
    logic         strike;
    logic [1:0]   state_out;
    logic [N-1:0] cut_mask;

    wires_module #(
        .NUM_WIRES      (N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .version  (version),
        .wires_in (wires_in),
        .defused  (defused),
        .strike   (strike),
        .state_out(state_out),
        .cut_mask (cut_mask)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t          sb [$];
    int           cyc = 0;
    int           m_state;
    logic [1:0]   m_ver;
    logic [N-1:0] m_mask;
    logic         m_def;
    logic [N-1:0] m_w;
    logic [N-1:0] m_fall;
    logic [N-1:0] m_cut;
    logic [N-1:0] hist [$];   // hist[0] = raw value sampled at the latest edge

    task automatic model_reset();
        m_state = 0;
        m_ver   = 2'd0;
        m_mask  = '0;
        m_def   = 1'b0;
        m_w     = '1;
        m_fall  = '0;
        m_cut   = '0;
        hist    = {};
        repeat (D + 2) hist.push_back('1);
    endtask

    task automatic model_step();
        logic [N-1:0] fresh;
        logic [N-1:0] nw;
        cyc++;
        if (!reset) begin
            model_reset();
            return;
        end
        // Puzzle rules act on the cut seen one edge earlier and the previous debounced wires.
        if (!enable) begin
            m_state = 0;
            m_def   = 1'b0;
        end else begin
            case (m_state)
                0: m_state = 1;
                1: if (m_w == '1) begin
                    m_state = 2;
                    m_ver   = version;
                    m_mask  = '0;
                end
                2: begin
                    fresh  = m_cut & ~m_mask;
                    m_mask = m_mask | m_cut;
                    if (fresh[TGT[m_ver]]) begin
                        m_state = 3;
                        m_def   = 1'b1;
                        sb.push_back('{EV_DEFUSED, cyc});
                    end else if (fresh != '0) begin
                        sb.push_back('{EV_STRIKE, cyc});
                    end
                end
                default: m_mask = m_mask | m_cut;
            endcase
        end
        m_cut = m_fall;
        // A wire flips once the raw value from two samples back has disagreed for D samples.
        hist.push_front(wires_in);
        void'(hist.pop_back());
        nw = m_w;
        for (int i = 0; i < N; i++) begin
            bit all_diff;
            all_diff = 1'b1;
            for (int j = 2; j <= D + 1; j++) begin
                if (hist[j][i] == m_w[i]) all_diff = 1'b0;
            end
            if (all_diff) nw[i] = ~m_w[i];
        end
        m_fall = m_w & ~nw;
        m_w    = nw;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock);
            model_step();
        end
    end

    // ---------------- monitor ----------------
    task automatic score_event(input int kind, input string name);
        ev_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected %s: got event at cycle %0d, expected none", name, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.cyc != cyc) begin
                n_fail++;
                $display("FAIL event %s: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                         name, kind, cyc, e.kind, e.cyc);
            end
        end
    endtask

    logic prev_def = 1'b0;

    initial begin
        forever begin
            @(negedge clock);
            if (strike === 1'b1) score_event(EV_STRIKE, "strike");
            if (defused === 1'b1 && !prev_def) score_event(EV_DEFUSED, "defused");
            prev_def = (defused === 1'b1);
            check("state_out vs model", state_out, m_state);
            check("cut_mask vs model", cut_mask, m_mask);
            check("defused vs model", defused, m_def);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic disarm();
        enable   = 1'b0;
        wires_in = '1;
        tick(D + 6);
    endtask

    initial begin
        // Reset with all wires intact.
        tick(3);
        reset = 1'b1;
        check("reset state_out", state_out, 2'd0);
        check("reset cut_mask", cut_mask, 6'b0);
        check("reset defused", defused, 1'b0);
        check("reset strike", strike, 1'b0);

        // Arm with version 0 and cut the target wire.
        version = 2'd0;
        enable  = 1'b1;
        tick(1);
        check("arm step wait_intact", state_out, 2'd1);
        tick(1);
        check("arm step armed", state_out, 2'd2);
        wires_in[1] = 1'b0;
        tick(7);
        check("defused not before 8", defused, 1'b0);
        tick(1);
        check("defused at 8", defused, 1'b1);
        check("state defused", state_out, 2'd3);
        enable = 1'b0;
        tick(1);
        check("enable drop defused", defused, 1'b0);
        check("enable drop idle", state_out, 2'd0);
        disarm();

        // Wrong cut, re-cut of the same wire, then the correct wire.
        version = 2'd1;
        enable  = 1'b1;
        tick(3);
        check("v1 armed", state_out, 2'd2);
        wires_in[0] = 1'b0;
        tick(D + 5);
        check("wrong cut mask", cut_mask, 6'b000001);
        check("wrong cut stays armed", state_out, 2'd2);
        wires_in[0] = 1'b1;
        tick(D + 6);
        wires_in[0] = 1'b0;
        tick(D + 6);
        check("re-cut mask unchanged", cut_mask, 6'b000001);
        wires_in[3] = 1'b0;
        tick(D + 6);
        check("v1 target defused", defused, 1'b1);
        check("v1 final mask", cut_mask, 6'b001001);
        disarm();

        // Bouncing wire 3 never registers; a steady cut does.
        version = 2'd1;
        enable  = 1'b1;
        tick(3);
        for (int k = 0; k < 10; k++) begin
            wires_in[3] = (k % 2 == 1);
            tick(2);
        end
        tick(D + 6);
        check("bounce no cut", cut_mask, 6'b0);
        check("bounce still armed", state_out, 2'd2);
        wires_in[3] = 1'b0;
        tick(D + 6);
        check("steady cut after bounce", defused, 1'b1);
        disarm();

        // Cut before enable blocks arming; version changes while armed are ignored.
        wires_in[2] = 1'b0;
        tick(D + 6);
        version = 2'd0;
        enable  = 1'b1;
        tick(D + 6);
        check("waits for intact", state_out, 2'd1);
        wires_in[2] = 1'b1;
        tick(D + 6);
        check("arms after restore", state_out, 2'd2);
        version = 2'd3;
        tick(2);
        wires_in[1] = 1'b0;
        tick(D + 6);
        check("latched version used", defused, 1'b1);
        disarm();

        // Simultaneous cuts including the target: defuse, no strike.
        version = 2'd2;
        enable  = 1'b1;
        tick(3);
        wires_in = 6'b011110;
        tick(D + 6);
        check("dual cut defused", defused, 1'b1);
        check("dual cut mask", cut_mask, 6'b100001);
        disarm();

        // Simultaneous wrong cuts: one strike only.
        version = 2'd2;
        enable  = 1'b1;
        tick(3);
        wires_in = 6'b111010;
        tick(D + 6);
        check("dual wrong armed", state_out, 2'd2);
        check("dual wrong mask", cut_mask, 6'b000101);

        // Reset while armed.
        reset = 1'b0;
        tick(1);
        check("reset armed state", state_out, 2'd0);
        check("reset armed mask", cut_mask, 6'b0);
        check("reset armed defused", defused, 1'b0);
        check("reset armed strike", strike, 1'b0);
        reset = 1'b1;
        disarm();

        // Randomized play against the model.
        enable = 1'b1;
        for (int it = 0; it < 600; it++) begin
            int r;
            int b;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                reset = 1'b0;
                tick(1);
                reset = 1'b1;
            end else if (r < 8) begin
                enable = ~enable;
            end
            version = 2'($urandom);
            b = $urandom_range(0, N - 1);
            if (m_state >= 2) wires_in[b] = ($urandom_range(0, 3) == 0);
            else              wires_in[b] = ($urandom_range(0, 7) != 0);
            tick($urandom_range(1, 8));
        end

        enable = 1'b0;
        tick(20);
        check("scoreboard drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
